// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen limits, facing and bullet FSM state types
package game_pkg;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FLYING   = 2'b01,
    COOLDOWN = 2'b10
  } bullet_state_t;

endpackage

// File: rtl/bullet_step.sv
// rtl/bullet_step.sv - one step of motion along a facing, with off-screen flag
// BULLET_WRAP_EN: next_x/next_y wrap modulo the screen size instead of passing through raw.
module bullet_step
  import game_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  dir_t       dir,
  input  logic [9:0] step,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       off_screen
);

  localparam logic signed [11:0] XMAX = 12'(SCREEN_X_MAX);
  localparam logic signed [11:0] YMAX = 12'(SCREEN_Y_MAX);

  logic signed [11:0] sx;
  logic signed [11:0] sy;
  logic signed [11:0] sstep;

  // Signed headroom so a step past 0 reads as negative rather than wrapping to a large value.
  always_comb begin
    sstep = $signed({2'b00, step});
    sx    = $signed({2'b00, x});
    sy    = $signed({2'b00, y});
    case (dir)
      UP:      sy = sy - sstep;
      DOWN:    sy = sy + sstep;
      LEFT:    sx = sx - sstep;
      default: sx = sx + sstep;
    endcase
  end

  assign off_screen = (sx < 12'sd0) || (sx > XMAX) || (sy < 12'sd0) || (sy > YMAX);

`ifdef BULLET_WRAP_EN
  always_comb begin
    next_x = sx[9:0];
    if (sx < 12'sd0) next_x = 10'(sx + (XMAX + 12'sd1));
    else if (sx > XMAX) next_x = 10'(sx - (XMAX + 12'sd1));
    next_y = sy[9:0];
    if (sy < 12'sd0) next_y = 10'(sy + (YMAX + 12'sd1));
    else if (sy > YMAX) next_y = 10'(sy - (YMAX + 12'sd1));
  end
`else
  assign next_x = sx[9:0];
  assign next_y = sy[9:0];
`endif

endmodule

// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - per-player bullet: spawn on fire edge, fly, retire, cool down
// BULLET_WRAP_EN: bullets wrap at screen edges and retire after MAX_FLIGHT moves instead.
module bullet_controller
  import game_pkg::*;
#(
  parameter int BULLET_STEP     = 4,
  parameter int SPAWN_OFFSET    = 8,
  parameter int BULLET_SIZE     = 2,
`ifdef BULLET_WRAP_EN
  parameter int MAX_FLIGHT      = 255,
`endif
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [1:0] dir,
  input  logic       target_hit,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] Bullet_Size,
  output logic       bullet_on,
  output logic       ready
);

  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  bullet_state_t state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic          on_q, on_d;
  logic          ready_q, ready_d;
  logic          fire_q, fire_d;
  logic [CW-1:0] cd_q, cd_d;

`ifdef BULLET_WRAP_EN
  localparam int FW = $clog2(MAX_FLIGHT + 1);
  logic [FW-1:0] flight_q, flight_d;
`endif

  logic       launch;
  logic [9:0] spawn_x, spawn_y, move_x, move_y;
  logic       spawn_off, move_off;

  assign launch = fire & ~fire_q;

  bullet_step u_spawn (
    .x          (PlayerX),
    .y          (PlayerY),
    .dir        (dir_t'(dir)),
    .step       (10'(SPAWN_OFFSET)),
    .next_x     (spawn_x),
    .next_y     (spawn_y),
    .off_screen (spawn_off)
  );

  bullet_step u_move (
    .x          (bx_q),
    .y          (by_q),
    .dir        (dir_q),
    .step       (10'(BULLET_STEP)),
    .next_x     (move_x),
    .next_y     (move_y),
    .off_screen (move_off)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bx_d    = bx_q;
    by_d    = by_q;
    on_d    = on_q;
    ready_d = ready_q;
    cd_d    = cd_q;
    fire_d  = fire;
`ifdef BULLET_WRAP_EN
    flight_d = flight_q;
`endif
    case (state_q)
      IDLE: begin
        if (launch && !spawn_off) begin
          state_d = FLYING;
          dir_d   = dir_t'(dir);
          bx_d    = spawn_x;
          by_d    = spawn_y;
          on_d    = 1'b1;
          ready_d = 1'b0;
`ifdef BULLET_WRAP_EN
          flight_d = '0;
`endif
        end
      end
      FLYING: begin
        // A hit wins over every other exit so the detector sees bullet_on drop exactly once.
`ifdef BULLET_WRAP_EN
        if (target_hit || flight_q == FW'(MAX_FLIGHT)) begin
`else
        if (target_hit || move_off) begin
`endif
          state_d = COOLDOWN;
          on_d    = 1'b0;
          cd_d    = CW'(COOLDOWN_FRAMES - 1);
        end else begin
          bx_d = move_x;
          by_d = move_y;
`ifdef BULLET_WRAP_EN
          flight_d = flight_q + 1'b1;
`endif
        end
      end
      COOLDOWN: begin
        if (cd_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cd_d = cd_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        on_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q   <= UP;
      bx_q    <= '0;
      by_q    <= '0;
      on_q    <= 1'b0;
      ready_q <= 1'b1;
      fire_q  <= 1'b0;
      cd_q    <= '0;
`ifdef BULLET_WRAP_EN
      flight_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      on_q    <= on_d;
      ready_q <= ready_d;
      fire_q  <= fire_d;
      cd_q    <= cd_d;
`ifdef BULLET_WRAP_EN
      flight_q <= flight_d;
`endif
    end
  end

  assign BulletX     = bx_q;
  assign BulletY     = by_q;
  assign Bullet_Size = 10'(BULLET_SIZE);
  assign bullet_on   = on_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_bullet_controller.sv
// tb/tb_bullet_controller.sv - directed self-checking bench for bullet_controller
module tb_bullet_controller;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       fire = 1'b0;
  logic       target_hit = 1'b0;
  logic [9:0] PlayerX = '0;
  logic [9:0] PlayerY = '0;
  logic [1:0] dir = 2'b00;
  logic [9:0] BulletX, BulletY, Bullet_Size;
  logic       bullet_on, ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 frame_clk = ~frame_clk;

  bullet_controller dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .fire        (fire),
    .PlayerX     (PlayerX),
    .PlayerY     (PlayerY),
    .dir         (dir),
    .target_hit  (target_hit),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .Bullet_Size (Bullet_Size),
    .bullet_on   (bullet_on),
    .ready       (ready)
  );

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    fire = 1'b0;
    target_hit = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic launch(input logic [9:0] px, input logic [9:0] py, input logic [1:0] d);
    PlayerX = px;
    PlayerY = py;
    dir = d;
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_flags: on=%0b ready=%0b want on=0 ready=1", bullet_on, ready);
    end
    n_cmp++;
    if (BulletX !== 10'd0 || BulletY !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", BulletX, BulletY);
    end
    n_cmp++;
    if (Bullet_Size !== 10'd2) begin
      n_bad++;
      $display("FAIL bullet_size: got %0d want 2", Bullet_Size);
    end
    Reset = 1'b0;
  endtask

  task automatic test_spawn_right;
    do_reset();
    launch(10'd320, 10'd240, 2'b11);
    n_cmp++;
    if (bullet_on !== 1'b1 || ready !== 1'b0 || BulletX !== 10'd328 || BulletY !== 10'd240) begin
      n_bad++;
      $display("FAIL spawn_right: on=%0b ready=%0b pos=(%0d,%0d) want on=1 ready=0 (328,240)",
               bullet_on, ready, BulletX, BulletY);
    end
    PlayerX = 10'd100;
    PlayerY = 10'd50;
    dir = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if (bullet_on !== 1'b1 || ready !== 1'b0 || BulletX !== 10'd340 || BulletY !== 10'd240) begin
      n_bad++;
      $display("FAIL fly_right: on=%0b ready=%0b pos=(%0d,%0d) want on=1 ready=0 (340,240)",
               bullet_on, ready, BulletX, BulletY);
    end
  endtask

  task automatic test_hit_cooldown;
    int zeros;
    logic on_seen;
    do_reset();
    launch(10'd392, 10'd240, 2'b11);
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd400) begin
      n_bad++;
      $display("FAIL hit_setup: on=%0b x=%0d want on=1 x=400", bullet_on, BulletX);
    end
    target_hit = 1'b1;
    tick();
    target_hit = 1'b0;
    n_cmp++;
    if (bullet_on !== 1'b0 || BulletX !== 10'd400 || BulletY !== 10'd240) begin
      n_bad++;
      $display("FAIL hit_retire: on=%0b pos=(%0d,%0d) want on=0 (400,240)", bullet_on, BulletX, BulletY);
    end
    zeros = (ready === 1'b0) ? 1 : 0;
    on_seen = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) fire = 1'b1;
      if (i == 6) fire = 1'b0;
      tick();
      if (ready === 1'b0) zeros++;
      if (bullet_on !== 1'b0) on_seen = 1'b1;
    end
    n_cmp++;
    if (zeros != 15) begin
      n_bad++;
      $display("FAIL cooldown_len: ready low %0d cycles want 15", zeros);
    end
    n_cmp++;
    if (on_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL cooldown_fire: bullet_on rose during cooldown, want no launch");
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1 || bullet_on !== 1'b0) begin
      n_bad++;
      $display("FAIL cooldown_end: ready=%0b on=%0b want ready=1 on=0", ready, bullet_on);
    end
    launch(10'd392, 10'd240, 2'b11);
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd400) begin
      n_bad++;
      $display("FAIL relaunch: on=%0b x=%0d want on=1 x=400", bullet_on, BulletX);
    end
  endtask

  task automatic test_spawn_offscreen;
    do_reset();
    launch(10'd320, 10'd4, 2'b00);
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b1 || BulletX !== 10'd0 || BulletY !== 10'd0) begin
      n_bad++;
      $display("FAIL spawn_off_up: on=%0b ready=%0b pos=(%0d,%0d) want on=0 ready=1 (0,0)",
               bullet_on, ready, BulletX, BulletY);
    end
    launch(10'd4, 10'd240, 2'b10);
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL spawn_off_left: on=%0b ready=%0b want on=0 ready=1", bullet_on, ready);
    end
  endtask

`ifndef BULLET_WRAP_EN
  task automatic test_screen_edge;
    do_reset();
    launch(10'd628, 10'd240, 2'b11);
    tick();
    n_cmp++;
    if (bullet_on !== 1'b0 || BulletX !== 10'd636) begin
      n_bad++;
      $display("FAIL edge_636: on=%0b x=%0d want on=0 x=636", bullet_on, BulletX);
    end
    do_reset();
    launch(10'd627, 10'd240, 2'b11);
    tick();
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd639) begin
      n_bad++;
      $display("FAIL edge_639: on=%0b x=%0d want on=1 x=639", bullet_on, BulletX);
    end
    do_reset();
    launch(10'd320, 10'd8, 2'b00);
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletY !== 10'd0) begin
      n_bad++;
      $display("FAIL edge_y0: on=%0b y=%0d want on=1 y=0", bullet_on, BulletY);
    end
    tick();
    n_cmp++;
    if (bullet_on !== 1'b0) begin
      n_bad++;
      $display("FAIL edge_y_neg: on=%0b want 0", bullet_on);
    end
  endtask

  task automatic test_hold_fire;
    int launches;
    logic prev;
    do_reset();
    PlayerX = 10'd320;
    PlayerY = 10'd240;
    dir = 2'b01;
    fire = 1'b1;
    tick();
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd320 || BulletY !== 10'd248) begin
      n_bad++;
      $display("FAIL hold_spawn: on=%0b pos=(%0d,%0d) want on=1 (320,248)", bullet_on, BulletX, BulletY);
    end
    launches = (bullet_on === 1'b1) ? 1 : 0;
    prev = bullet_on;
    for (int i = 2; i <= 100; i++) begin
      tick();
      if (bullet_on === 1'b1 && prev !== 1'b1) launches++;
      prev = bullet_on;
    end
    fire = 1'b0;
    n_cmp++;
    if (launches != 1) begin
      n_bad++;
      $display("FAIL hold_launches: got %0d want 1", launches);
    end
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b1 || BulletY !== 10'd476) begin
      n_bad++;
      $display("FAIL hold_end: on=%0b ready=%0b y=%0d want on=0 ready=1 y=476", bullet_on, ready, BulletY);
    end
  endtask
`else
  task automatic test_wrap;
    do_reset();
    launch(10'd630, 10'd240, 2'b11);
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd638) begin
      n_bad++;
      $display("FAIL wrap_spawn: on=%0b x=%0d want on=1 x=638", bullet_on, BulletX);
    end
    tick();
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd2) begin
      n_bad++;
      $display("FAIL wrap_x: on=%0b x=%0d want on=1 x=2", bullet_on, BulletX);
    end
    repeat (254) tick();
    n_cmp++;
    if (bullet_on !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_255_moves: on=%0b want 1", bullet_on);
    end
    tick();
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_lifetime: on=%0b ready=%0b want on=0 ready=0", bullet_on, ready);
    end
  endtask
`endif

  task automatic test_reset_mid_flight;
    do_reset();
    launch(10'd320, 10'd240, 2'b11);
    repeat (2) tick();
    n_cmp++;
    if (bullet_on !== 1'b1 || BulletX !== 10'd336) begin
      n_bad++;
      $display("FAIL midflight_setup: on=%0b x=%0d want on=1 x=336", bullet_on, BulletX);
    end
    Reset = 1'b1;
    target_hit = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if (bullet_on !== 1'b0 || ready !== 1'b1 || BulletX !== 10'd0 || BulletY !== 10'd0) begin
      n_bad++;
      $display("FAIL midflight_reset: on=%0b ready=%0b pos=(%0d,%0d) want on=0 ready=1 (0,0)",
               bullet_on, ready, BulletX, BulletY);
    end
    repeat (3) tick();
    n_cmp++;
    if (ready !== 1'b1 || bullet_on !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hit_ignored: ready=%0b on=%0b want ready=1 on=0", ready, bullet_on);
    end
    target_hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn_right();
    test_hit_cooldown();
    test_spawn_offscreen();
`ifndef BULLET_WRAP_EN
    test_screen_edge();
    test_hold_fire();
`else
    test_wrap();
`endif
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
